// File: rtl/maze_pkg.sv
// Shared encodings for the maze player logic: game states, move directions,
// walker FSM states and the flattened wall-map cell index.
package maze_pkg;

    localparam logic [1:0] ST_MENU = 2'b00;
    localparam logic [1:0] ST_PLAY = 2'b01;
    localparam logic [1:0] ST_WIN  = 2'b10;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    typedef enum logic [1:0] {
        W_IDLE  = 2'd0,
        W_READY = 2'd1,
        W_EXEC  = 2'd2
    } walk_state_t;

    function automatic logic [31:0] cell_idx(input logic [31:0] x,
                                             input logic [31:0] y,
                                             input logic [31:0] w);
        return y * w + x;
    endfunction

endpackage

// File: rtl/dir_fifo.sv
// Small synchronous FIFO of 2-bit direction codes; flush wins over push/pop.
module dir_fifo
    import maze_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic [1:0] din,
    input  logic       pop,
    input  logic       flush,
    output logic       full,
    output logic       empty,
    output logic [1:0] dout
);

    localparam int AW = $clog2(DEPTH);

    logic [1:0]  r_mem [DEPTH];
    logic [AW:0] r_wr;
    logic [AW:0] r_rd;
    logic        w_push;
    logic        w_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign full   = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
    assign empty  = (r_wr == r_rd);
    assign dout   = r_mem[r_rd[AW-1:0]];
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr <= '0;
            r_rd <= '0;
        end else if (flush) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + (AW+1)'(1);
            if (w_pop)  r_rd <= r_rd + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !flush) r_mem[r_wr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/maze_walker.sv
// Player move logic: queues direction keys, checks each popped move against
// the wall map, tracks position/steps and flags arrival at the goal.
module maze_walker
    import maze_pkg::*;
#(
    parameter int GRID_W  = 19,
    parameter int GRID_H  = 19,
    parameter int XW      = 5,
    parameter int YW      = 5,
    parameter int START_X = 1,
    parameter int START_Y = 1,
    parameter int GOAL_X  = 17,
    parameter int GOAL_Y  = 17,
    parameter int QDEPTH  = 4,
    parameter int WRAP    = 0,
    parameter int STEPW   = 10
) (
    input  logic                     clk,
    input  logic                     rst_sys,
    input  logic [1:0]               state,
    input  logic                     up,
    input  logic                     down,
    input  logic                     left,
    input  logic                     right,
    input  logic [GRID_W*GRID_H-1:0] map,
    output logic [XW-1:0]            x_index,
    output logic [YW-1:0]            y_index,
    output logic [STEPW-1:0]         step_cnt,
    output logic                     arrived,
    output logic                     blocked,
    output logic                     q_overflow
);

    localparam int CW = $clog2(GRID_W*GRID_H);

    walk_state_t      r_ws, w_ws_nxt;
    logic [XW-1:0]    r_x, w_tx;
    logic [YW-1:0]    r_y, w_ty;
    logic [STEPW-1:0] r_step;
    logic [1:0]       r_dir, w_din, w_dout;
    logic [CW-1:0]    w_cell;
    logic             r_arrived, r_blocked, r_ovf;
    logic             w_play, w_start, w_push, w_pop, w_flush, w_full, w_empty;
    logic             w_edge, w_reject, w_exec;

    assign w_play  = (state == ST_PLAY);
    // IDLE is only left through PLAY, so IDLE && PLAY marks the first PLAY cycle.
    assign w_start = w_play && (r_ws == W_IDLE);
    assign w_push  = w_play && !r_arrived && (up || down || left || right);
    assign w_flush = !w_play || w_start || r_arrived;
    assign w_exec  = w_play && (r_ws == W_EXEC);

    always_comb begin
        if (up)        w_din = DIR_UP;
        else if (down) w_din = DIR_DOWN;
        else if (left) w_din = DIR_LEFT;
        else           w_din = DIR_RIGHT;
    end

    dir_fifo #(.DEPTH(QDEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_sys),
        .push  (w_push),
        .din   (w_din),
        .pop   (w_pop),
        .flush (w_flush),
        .full  (w_full),
        .empty (w_empty),
        .dout  (w_dout)
    );

    always_comb begin
        w_ws_nxt = r_ws;
        w_pop    = 1'b0;
        if (!w_play) begin
            w_ws_nxt = W_IDLE;
        end else begin
            case (r_ws)
                W_IDLE:  w_ws_nxt = W_READY;
                W_READY: if (!w_empty && !r_arrived) begin
                    w_pop    = 1'b1;
                    w_ws_nxt = W_EXEC;
                end
                W_EXEC:  w_ws_nxt = W_READY;
                default: w_ws_nxt = W_IDLE;
            endcase
        end
    end

    // The wrapped coordinate is produced even without WRAP so the map index stays in range.
    always_comb begin
        w_tx   = r_x;
        w_ty   = r_y;
        w_edge = 1'b0;
        case (r_dir)
            DIR_UP:
                if (r_y == '0) begin w_edge = 1'b1; w_ty = YW'(GRID_H-1); end
                else w_ty = r_y - YW'(1);
            DIR_DOWN:
                if (r_y == YW'(GRID_H-1)) begin w_edge = 1'b1; w_ty = '0; end
                else w_ty = r_y + YW'(1);
            DIR_LEFT:
                if (r_x == '0) begin w_edge = 1'b1; w_tx = XW'(GRID_W-1); end
                else w_tx = r_x - XW'(1);
            default:
                if (r_x == XW'(GRID_W-1)) begin w_edge = 1'b1; w_tx = '0; end
                else w_tx = r_x + XW'(1);
        endcase
    end

    assign w_cell   = CW'(cell_idx(32'(w_tx), 32'(w_ty), 32'(GRID_W)));
    assign w_reject = (w_edge && (WRAP == 0)) || map[w_cell];

    always_ff @(posedge clk or negedge rst_sys) begin
        if (!rst_sys) begin
            r_ws      <= W_IDLE;
            r_x       <= XW'(START_X);
            r_y       <= YW'(START_Y);
            r_step    <= '0;
            r_dir     <= DIR_UP;
            r_arrived <= 1'b0;
            r_blocked <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            r_ws      <= w_ws_nxt;
            r_blocked <= w_exec && w_reject;
            if (w_pop) r_dir <= w_dout;
            if (w_start) begin
                r_x       <= XW'(START_X);
                r_y       <= YW'(START_Y);
                r_step    <= '0;
                r_arrived <= 1'b0;
                r_ovf     <= 1'b0;
            end else begin
                if (w_exec && !w_reject) begin
                    r_x <= w_tx;
                    r_y <= w_ty;
                    if (r_step != '1) r_step <= r_step + STEPW'(1);
                end
                if (w_push && w_full) r_ovf <= 1'b1;
                if (r_x == XW'(GOAL_X) && r_y == YW'(GOAL_Y)) r_arrived <= 1'b1;
            end
        end
    end

    assign x_index    = r_x;
    assign y_index    = r_y;
    assign step_cnt   = r_step;
    assign arrived    = r_arrived;
    assign blocked    = r_blocked;
    assign q_overflow = r_ovf;

endmodule

// File: tb/tb_maze_walker.sv
// Bench for maze_walker: instance 0 without wrap, instance 1 with wrap; a grid
// model predicts each move result, which a monitor compares as the DUT reports it.
module tb_maze_walker;

    localparam int GW = 19;
    localparam int GH = 19;
    localparam int MW = GW*GH;

    typedef struct {
        int x;
        int y;
        int step;
        bit blk;
    } ev_t;

    logic          clk = 1'b0;
    logic          rst_sys;
    logic [1:0]    st    [2];
    logic [3:0]    key   [2];   // {up, down, left, right}
    logic [MW-1:0] mp    [2];
    logic [4:0]    ox    [2];
    logic [4:0]    oy    [2];
    logic [9:0]    ostep [2];
    logic          oarr  [2];
    logic          oblk  [2];
    logic          oovf  [2];

    int  vectors     = 0;
    int  miscompares = 0;
    int  mx [2];
    int  my [2];
    int  mstep [2];
    logic [4:0] px [2];
    logic [4:0] py [2];
    bit  mon_on = 0;
    ev_t q0 [$];
    ev_t q1 [$];

    always #5 clk = ~clk;

    maze_walker #(.WRAP(0)) dut0 (
        .clk(clk), .rst_sys(rst_sys), .state(st[0]),
        .up(key[0][3]), .down(key[0][2]), .left(key[0][1]), .right(key[0][0]),
        .map(mp[0]), .x_index(ox[0]), .y_index(oy[0]), .step_cnt(ostep[0]),
        .arrived(oarr[0]), .blocked(oblk[0]), .q_overflow(oovf[0])
    );

    maze_walker #(.WRAP(1)) dut1 (
        .clk(clk), .rst_sys(rst_sys), .state(st[1]),
        .up(key[1][3]), .down(key[1][2]), .left(key[1][1]), .right(key[1][0]),
        .map(mp[1]), .x_index(ox[1]), .y_index(oy[1]), .step_cnt(ostep[1]),
        .arrived(oarr[1]), .blocked(oblk[1]), .q_overflow(oovf[1])
    );

    // Scoreboard monitor: every position change or blocked pulse is one result.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (mon_on && (oblk[i] === 1'b1 || ox[i] !== px[i] || oy[i] !== py[i])) begin
                ev_t e;
                bit  got;
                got = 0;
                if (i == 0 && q0.size() > 0) begin e = q0.pop_front(); got = 1; end
                if (i == 1 && q1.size() > 0) begin e = q1.pop_front(); got = 1; end
                vectors++;
                if (!got) begin
                    miscompares++;
                    $display("FAIL sb%0d_unexpected got x=%0d y=%0d step=%0d blk=%0b, expected no event",
                             i, ox[i], oy[i], ostep[i], oblk[i]);
                end else if (ox[i] !== 5'(e.x) || oy[i] !== 5'(e.y) ||
                             ostep[i] !== 10'(e.step) || oblk[i] !== e.blk) begin
                    miscompares++;
                    $display("FAIL sb%0d_event got x=%0d y=%0d step=%0d blk=%0b, expected x=%0d y=%0d step=%0d blk=%0b",
                             i, ox[i], oy[i], ostep[i], oblk[i], e.x, e.y, e.step, e.blk);
                end
            end
            px[i] = ox[i];
            py[i] = oy[i];
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Grid model: predicts the outcome of one popped move and queues it.
    task automatic expect_move(input int i, input int d);
        int  tx, ty;
        bit  edge_hit, rej;
        ev_t e;
        tx = mx[i]; ty = my[i]; edge_hit = 0;
        case (d)
            0: if (ty == 0)      begin edge_hit = 1; ty = GH-1; end else ty = ty - 1;
            1: if (ty == GH-1)   begin edge_hit = 1; ty = 0;    end else ty = ty + 1;
            2: if (tx == 0)      begin edge_hit = 1; tx = GW-1; end else tx = tx - 1;
            default: if (tx == GW-1) begin edge_hit = 1; tx = 0; end else tx = tx + 1;
        endcase
        rej = (edge_hit && i == 0) || (mp[i][ty*GW+tx] == 1'b1);
        if (!rej) begin
            mx[i] = tx; my[i] = ty;
            if (mstep[i] < 1023) mstep[i] = mstep[i] + 1;
        end
        e.x = mx[i]; e.y = my[i]; e.step = mstep[i]; e.blk = rej;
        if (i == 0) q0.push_back(e); else q1.push_back(e);
    endtask

    // One key pulse, sampled by the DUT at the second edge; returns 1 ns after it.
    task automatic pulse(input int i, input logic [3:0] k);
        @(posedge clk); #1;
        key[i] = k;
        @(posedge clk); #1;
        key[i] = 4'b0000;
    endtask

    task automatic move(input int i, input logic [3:0] k, input int d);
        expect_move(i, d);
        pulse(i, k);
    endtask

    task automatic drain_check(input int i, input string name);
        idle(6);
        vectors++;
        if ((i == 0 ? q0.size() : q1.size()) != 0) begin
            miscompares++;
            $display("FAIL %s_pending got %0d results outstanding, expected 0", name,
                     (i == 0 ? q0.size() : q1.size()));
        end
    endtask

    task automatic restart(input int i, input string name);
        mon_on = 0;
        st[i] = 2'b00;
        idle(3);
        st[i] = 2'b01;
        idle(3);
        vectors++;
        if (ox[i] !== 5'd1 || oy[i] !== 5'd1 || ostep[i] !== 10'd0 || oarr[i] !== 1'b0 || oovf[i] !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_restart got x=%0d y=%0d step=%0d arr=%0b ovf=%0b, expected 1 1 0 0 0",
                     name, ox[i], oy[i], ostep[i], oarr[i], oovf[i]);
        end
        mx[i] = 1; my[i] = 1; mstep[i] = 0;
        @(negedge clk);
        mon_on = 1;
    endtask

    task automatic test_reset();
        rst_sys = 1'b0;
        for (int i = 0; i < 2; i++) begin
            st[i] = 2'b00; key[i] = 4'b0000; mp[i] = '0;
            mx[i] = 1; my[i] = 1; mstep[i] = 0;
        end
        idle(3);
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if (ox[i] !== 5'd1 || oy[i] !== 5'd1 || ostep[i] !== 10'd0 ||
                oarr[i] !== 1'b0 || oblk[i] !== 1'b0 || oovf[i] !== 1'b0) begin
                miscompares++;
                $display("FAIL reset%0d got x=%0d y=%0d step=%0d arr=%0b blk=%0b ovf=%0b, expected 1 1 0 0 0 0",
                         i, ox[i], oy[i], ostep[i], oarr[i], oblk[i], oovf[i]);
            end
        end
        st[0] = 2'b01; st[1] = 2'b01;
        @(negedge clk);
        rst_sys = 1'b1;
        idle(3);
        @(negedge clk);
        mon_on = 1;
    endtask

    task automatic test_single_move();
        move(0, 4'b0001, 3);
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (ox[0] !== 5'd1) begin
            miscompares++;
            $display("FAIL move_early got x=%0d after edge k+1, expected 1", ox[0]);
        end
        @(negedge clk);
        vectors++;
        if (ox[0] !== 5'd2 || oy[0] !== 5'd1 || ostep[0] !== 10'd1 || oblk[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL move_right got x=%0d y=%0d step=%0d blk=%0b, expected 2 1 1 0",
                     ox[0], oy[0], ostep[0], oblk[0]);
        end
        drain_check(0, "move_right");
    endtask

    task automatic test_wall();
        restart(0, "wall");
        mp[0][39] = 1'b1;
        move(0, 4'b0100, 1);
        @(negedge clk); @(negedge clk); @(negedge clk);
        vectors++;
        if (oblk[0] !== 1'b1 || ox[0] !== 5'd1 || oy[0] !== 5'd1 || ostep[0] !== 10'd0) begin
            miscompares++;
            $display("FAIL wall_block got blk=%0b x=%0d y=%0d step=%0d, expected 1 1 1 0",
                     oblk[0], ox[0], oy[0], ostep[0]);
        end
        @(negedge clk);
        vectors++;
        if (oblk[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL wall_pulse got blk=%0b one cycle later, expected 0", oblk[0]);
        end
        drain_check(0, "wall");
        mp[0][39] = 1'b0;
    endtask

    // Left held for 8 edges: the queue drains one entry per two cycles, so it
    // fills on the 7th push and the 8th is dropped.
    task automatic test_back_to_back();
        restart(0, "b2b");
        for (int j = 0; j < 7; j++) expect_move(0, 2);
        @(posedge clk); #1;
        key[0] = 4'b0010;
        for (int j = 0; j < 8; j++) begin
            @(posedge clk); #1;
            if (j == 6) begin
                vectors++;
                if (oovf[0] !== 1'b0) begin
                    miscompares++;
                    $display("FAIL b2b_full got ovf=%0b with queue just full, expected 0", oovf[0]);
                end
            end
        end
        key[0] = 4'b0000;
        vectors++;
        if (oovf[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_overflow got ovf=%0b, expected 1", oovf[0]);
        end
        idle(14);
        vectors++;
        if (ox[0] !== 5'd0 || oy[0] !== 5'd1 || ostep[0] !== 10'd1 || oovf[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_final got x=%0d y=%0d step=%0d ovf=%0b, expected 0 1 1 1",
                     ox[0], oy[0], ostep[0], oovf[0]);
        end
        drain_check(0, "b2b");
    endtask

    task automatic test_wrap();
        move(1, 4'b0010, 2);
        move(1, 4'b0010, 2);
        idle(3);
        vectors++;
        if (ox[1] !== 5'd18 || oy[1] !== 5'd1) begin
            miscompares++;
            $display("FAIL wrap_left got x=%0d y=%0d, expected 18 1", ox[1], oy[1]);
        end
        move(1, 4'b0001, 3);
        idle(3);
        mp[1][1*GW+18] = 1'b1;
        move(1, 4'b0010, 2);
        idle(3);
        vectors++;
        if (ox[1] !== 5'd0 || ostep[1] !== 10'd3) begin
            miscompares++;
            $display("FAIL wrap_wall got x=%0d step=%0d, expected 0 3", ox[1], ostep[1]);
        end
        drain_check(1, "wrap");
        mp[1] = '0;
    endtask

    task automatic test_priority();
        restart(0, "prio");
        move(0, 4'b0100, 1);
        idle(3);
        move(0, 4'b1001, 0);
        idle(3);
        vectors++;
        if (ox[0] !== 5'd1 || oy[0] !== 5'd1 || ostep[0] !== 10'd2) begin
            miscompares++;
            $display("FAIL prio_up got x=%0d y=%0d step=%0d, expected 1 1 2", ox[0], oy[0], ostep[0]);
        end
        drain_check(0, "prio");
    endtask

    task automatic test_goal();
        restart(0, "goal");
        for (int j = 0; j < 16; j++) move(0, 4'b0001, 3);
        for (int j = 0; j < 15; j++) move(0, 4'b0100, 1);
        move(0, 4'b0100, 1);
        @(negedge clk); @(negedge clk); @(negedge clk);
        vectors++;
        if (ox[0] !== 5'd17 || oy[0] !== 5'd17 || oarr[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL goal_reach got x=%0d y=%0d arr=%0b, expected 17 17 0", ox[0], oy[0], oarr[0]);
        end
        @(negedge clk);
        vectors++;
        if (oarr[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL goal_arrived got arr=%0b, expected 1", oarr[0]);
        end
        pulse(0, 4'b0010);
        pulse(0, 4'b1000);
        idle(6);
        vectors++;
        if (ox[0] !== 5'd17 || oy[0] !== 5'd17 || ostep[0] !== 10'd32 || oovf[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL goal_ignore got x=%0d y=%0d step=%0d ovf=%0b, expected 17 17 32 0",
                     ox[0], oy[0], ostep[0], oovf[0]);
        end
        st[0] = 2'b00;
        idle(3);
        vectors++;
        if (ox[0] !== 5'd17 || oarr[0] !== 1'b1 || ostep[0] !== 10'd32) begin
            miscompares++;
            $display("FAIL goal_hold got x=%0d arr=%0b step=%0d in MENU, expected 17 1 32",
                     ox[0], oarr[0], ostep[0]);
        end
        drain_check(0, "goal");
        restart(0, "goal");
    endtask

    initial begin
        test_reset();
        test_single_move();
        test_wall();
        test_back_to_back();
        test_wrap();
        test_priority();
        test_goal();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
